// File: rtl/gray_pkg.sv
// Shared Gray-code definitions: mode encoding and width-agnostic conversion helpers.
package gray_pkg;

    localparam logic MODE_B2G = 1'b0;
    localparam logic MODE_G2B = 1'b1;

    localparam int MAX_WIDTH = 32;

    function automatic logic [MAX_WIDTH-1:0] bin_to_gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Callers pass narrower words zero-extended; the zero upper bits leave the
    // prefix XOR of the live bits unchanged, so one 32-bit body serves all widths.
    function automatic logic [MAX_WIDTH-1:0] gray_to_bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_pipe_reg.sv
// Single valid/ready pipeline register carrying a data word and its conversion mode.
module gray_pipe_reg
    import gray_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode
);

    // Handshake: a word moves on a rising edge where valid and ready are both 1.
    // valid never looks at ready; ready may follow the downstream ready combinationally.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mode  <= MODE_B2G;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
                out_mode <= in_mode;
            end
        end
    end

endmodule

// File: rtl/gray_codec_pipe.sv
// Two-stage binary<->Gray converter: capture register, conversion, result register, transfer counter.
module gray_codec_pipe
    import gray_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter bit SAT_CNT = 1'b1
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic [15:0]      xfer_cnt
);

    logic             s1_valid;
    logic             s1_mode;
    logic             s2_ready;
    logic [WIDTH-1:0] s1_data;
    logic [WIDTH-1:0] conv_data;
    logic [31:0]      s1_ext;

    gray_pipe_reg #(.WIDTH(WIDTH)) u_s1 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_data),
        .out_mode  (s1_mode)
    );

    assign s1_ext = 32'(s1_data);

    always_comb begin
        conv_data = WIDTH'(bin_to_gray(s1_ext));
        if (s1_mode == MODE_G2B) begin
            conv_data = WIDTH'(gray_to_bin(s1_ext));
        end
    end

    gray_pipe_reg #(.WIDTH(WIDTH)) u_s2 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (conv_data),
        .in_mode   (s1_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode)
    );

    // Counts completed output transfers; saturating or wrapping at all-ones.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            xfer_cnt <= 16'd0;
        end else if (out_valid && out_ready) begin
            if (SAT_CNT && xfer_cnt == 16'hFFFF) begin
                xfer_cnt <= xfer_cnt;
            end else begin
                xfer_cnt <= xfer_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/gray_codec_pipe.md
GRAY_CODEC_PIPE -- requirements
Module: gray_codec_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; legal range 2..32.
REQ-002 Parameter SAT_CNT, default 1; 1 = transaction counter saturates at all-ones, 0 = counter wraps.
REQ-003 sys_clk  input  1  clock; all state updates on rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  input word present.
REQ-006 in_ready  output  1  block accepts input this cycle.
REQ-007 in_mode  input  1  0 = binary-to-Gray, 1 = Gray-to-binary; sampled with in_data.
REQ-008 in_data  input  WIDTH  word to convert.
REQ-009 out_valid  output  1  converted word present.
REQ-010 out_ready  input  1  consumer accepts output this cycle.
REQ-011 out_data  output  WIDTH  converted word.
REQ-012 out_mode  output  1  mode the out_data word was converted with.
REQ-013 xfer_cnt  output  16  count of completed output transfers.

Function
REQ-014 Input transfer occurs on a rising edge with in_valid=1 and in_ready=1; output transfer occurs with out_valid=1 and out_ready=1.
REQ-015 Two-stage pipeline S1 (capture) -> S2 (convert and register); first-word latency is exactly 2 cycles from input transfer to out_valid=1.
REQ-016 S1 registers in_data and in_mode unchanged; S2 registers the converted result and mode.
REQ-017 Mode 0: out_data = d XOR (d >> 1), logical shift, zero fill at MSB.
REQ-018 Mode 1: out_data[WIDTH-1] = g[WIDTH-1]; out_data[i] = out_data[i+1] XOR g[i] for i below WIDTH-1.
REQ-019 S2 loads when it is empty or its word transfers out in the same cycle; S1 loads under the same rule relative to S2.
REQ-020 in_ready = S1 empty, or S1 advancing into S2 in the same cycle; combinational path from out_ready to in_ready is permitted.
REQ-021 With out_ready held at 1 and in_valid held at 1, throughput is one word per cycle with no bubbles.
REQ-022 With out_ready=0 and both stages full, in_ready=0; out_data and out_mode hold stable until the output transfers.
REQ-023 Once out_valid=1 it stays 1 until the output transfers; out_valid never drops without a transfer.
REQ-024 Word order is preserved; modes may alternate word by word with no flush or dead cycle.
REQ-025 xfer_cnt increments by 1 on every output transfer. At 16'hFFFF it holds when SAT_CNT=1 and wraps to 0 when SAT_CNT=0.
REQ-026 Simultaneous input and output transfer in the same cycle with both stages full is accepted; the pipeline shifts and no word is lost or duplicated.

Reset
REQ-027 sys_rst_n=0 asynchronously clears the S1 and S2 valid flags, so out_valid=0.
REQ-028 sys_rst_n=0 asynchronously clears out_data to 0, out_mode to 0, xfer_cnt to 0, and the S1 data and mode registers to 0.
REQ-029 in_ready=1 in the first cycle after reset deassertion.
REQ-030 Reset mid-operation discards all in-flight words; no output transfer of pre-reset data occurs afterwards.

Structure
REQ-031 Shared package gray_pkg holds the mode constants MODE_B2G=0 and MODE_G2B=1.
REQ-032 gray_pkg also holds parametrised-width conversion functions bin_to_gray and gray_to_bin, reused by future Gray pointer blocks.
REQ-033 One sub-module gray_pipe_reg implements a single valid/ready pipeline register (data and mode payload); it is instantiated twice.
REQ-034 The conversion logic sits between the two gray_pipe_reg instances.

Verification
REQ-035 WIDTH=8, out_ready=1: mode 0, in_data 8'h0B -> out_data 8'h0E, out_mode 0, 2 cycles after the input transfer.
REQ-036 WIDTH=8: mode 1, 8'h0E -> 8'h0B; mode 0, 8'hFF -> 8'h80; mode 1, 8'h80 -> 8'hFF; words sent back-to-back, out_valid on 3 consecutive cycles.
REQ-037 WIDTH=4: full sweep 0..15 in mode 0, outputs fed back in mode 1. Each mode-0 output differs from its predecessor in exactly 1 bit; each round trip returns the original value.
REQ-038 Backpressure: hold out_ready=0 for 5 cycles while sending 4 words. in_ready falls after 2 accepted words; out_data stays stable; after release, all 4 words exit in order.
REQ-039 Reset pulse with 2 words in flight -> out_valid=0 immediately, xfer_cnt=0, no stale word appears after reset.
REQ-040 Preload 65535 transfers: SAT_CNT=1 -> xfer_cnt stays 16'hFFFF on the next transfer; SAT_CNT=0 -> xfer_cnt becomes 0.
